bus_device_port: RTL and testbench

Device-side endpoint of the shared bus generator/arbiter. Each instance sits between one device and one bus port.
- TX FIFO: holds locally written packets, raises `pndng` and presents the head word on `D_pop` until the bus pops it.
- RX side: accepts bus `push` writes, filters them by destination ID (unicast or broadcast) and queues accepted packets for the device.
- Replaces the behavioural driver FIFO model with synthesizable RTL, so a bus port can be closed by hardware.

---
 rtl/bus_device_port.sv | 123 ++++++++++++
 tb/tb_bus_device_port.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/bus_device_port.sv
// Device-side bus endpoint: a show-ahead TX FIFO popped by the bus, and a show-ahead
// RX FIFO filled by bus pushes whose destination ID matches this device or broadcast.
module bus_device_port #(
  parameter int          pckg_sz   = 16,
  parameter int          depth     = 8,
  parameter logic [7:0]  id        = 8'd0,
  parameter logic [7:0]  broadcast = 8'b1000_1111
) (
  input  logic               clk,
  input  logic               reset,
  output logic               pndng,
  output logic [pckg_sz-1:0] D_pop,
  input  logic               pop,
  input  logic               push,
  input  logic [pckg_sz-1:0] D_push,
  input  logic               tx_wr,
  input  logic [pckg_sz-1:0] tx_data,
  output logic               tx_full,
  input  logic               rx_rd,
  output logic [pckg_sz-1:0] rx_data,
  output logic               rx_empty,
  output logic [7:0]         drop_cnt,
  output logic               err
);

  // Handshake: pndng/!rx_empty act as "valid"; a transfer happens in the cycle its
  // strobe (pop, rx_rd) is high while valid, and the head word moves after that edge.
  localparam int              PW       = $clog2(depth);
  localparam logic [PW:0]     FULL_CNT = (PW+1)'(depth);

  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [PW-1:0]      tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PW:0]        tx_cnt_q, tx_cnt_d;
  logic               tx_pndng_q, tx_full_q;
  logic               tx_do_wr, tx_do_pop;

  logic [pckg_sz-1:0] rx_mem_q [depth];
  logic [PW-1:0]      rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [PW:0]        rx_cnt_q, rx_cnt_d;
  logic               rx_empty_q, rx_full;
  logic               rx_accept, rx_do_wr, rx_do_rd, rx_drop;
  logic [7:0]         dst;

  logic [7:0]         drop_q, drop_d;
  logic               err_q, err_d;

  always_comb begin
    tx_do_pop = pop && tx_pndng_q;
    // When full, a write is only possible because the simultaneous pop frees a slot.
    tx_do_wr  = tx_wr && (!tx_full_q || tx_do_pop);
    tx_wptr_d = tx_do_wr  ? tx_wptr_q + PW'(1) : tx_wptr_q;
    tx_rptr_d = tx_do_pop ? tx_rptr_q + PW'(1) : tx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    if (tx_do_wr && !tx_do_pop)      tx_cnt_d = tx_cnt_q + (PW+1)'(1);
    else if (!tx_do_wr && tx_do_pop) tx_cnt_d = tx_cnt_q - (PW+1)'(1);
  end

  always_comb begin
    dst       = D_push[pckg_sz-1 -: 8];
    rx_full   = (rx_cnt_q == FULL_CNT);
    rx_accept = push && ((dst == id) || (dst == broadcast));
    rx_do_rd  = rx_rd && !rx_empty_q;
    rx_do_wr  = rx_accept && (!rx_full || rx_do_rd);
    rx_drop   = rx_accept && rx_full && !rx_do_rd;
    rx_wptr_d = rx_do_wr ? rx_wptr_q + PW'(1) : rx_wptr_q;
    rx_rptr_d = rx_do_rd ? rx_rptr_q + PW'(1) : rx_rptr_q;
    rx_cnt_d  = rx_cnt_q;
    if (rx_do_wr && !rx_do_rd)      rx_cnt_d = rx_cnt_q + (PW+1)'(1);
    else if (!rx_do_wr && rx_do_rd) rx_cnt_d = rx_cnt_q - (PW+1)'(1);
  end

  always_comb begin
    drop_d = drop_q;
    if (rx_drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
    err_d = err_q
          | (pop && !tx_pndng_q)
          | (tx_wr && tx_full_q && !pop)
          | (rx_rd && rx_empty_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_cnt_q   <= '0;
      tx_pndng_q <= 1'b0;
      tx_full_q  <= 1'b0;
      rx_wptr_q  <= '0;
      rx_rptr_q  <= '0;
      rx_cnt_q   <= '0;
      rx_empty_q <= 1'b1;
      drop_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      tx_wptr_q  <= tx_wptr_d;
      tx_rptr_q  <= tx_rptr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_pndng_q <= (tx_cnt_d != '0);
      tx_full_q  <= (tx_cnt_d == FULL_CNT);
      rx_wptr_q  <= rx_wptr_d;
      rx_rptr_q  <= rx_rptr_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_empty_q <= (rx_cnt_d == '0);
      drop_q     <= drop_d;
      err_q      <= err_d;
    end
  end

  // Storage needs no reset: the outputs are masked to zero whenever a FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && tx_do_wr) tx_mem_q[tx_wptr_q] <= tx_data;
    if (!reset && rx_do_wr) rx_mem_q[rx_wptr_q] <= D_push;
  end

  assign pndng    = tx_pndng_q;
  assign tx_full  = tx_full_q;
  assign D_pop    = tx_pndng_q ? tx_mem_q[tx_rptr_q] : '0;
  assign rx_empty = rx_empty_q;
  assign rx_data  = rx_empty_q ? '0 : rx_mem_q[rx_rptr_q];
  assign drop_cnt = drop_q;
  assign err      = err_q;

endmodule

// File: tb/tb_bus_device_port.sv
// Directed bench for bus_device_port (id = 2): vector table for single-cycle behaviour,
// hand-written sequences for fill/drain, overflow and drop-counter saturation.
module tb_bus_device_port;

  logic        clk = 1'b0;
  logic        reset, pndng, pop, push, tx_wr, tx_full, rx_rd, rx_empty, err;
  logic [15:0] D_pop, D_push, tx_data, rx_data;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  bus_device_port #(.pckg_sz(16), .depth(8), .id(8'd2), .broadcast(8'h8F)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data), .tx_full(tx_full),
    .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty), .drop_cnt(drop_cnt), .err(err)
  );

  typedef struct {
    logic        rst, wr; logic [15:0] wd; logic pp, ps; logic [15:0] pd; logic rd;
    logic        e_pndng; logic [15:0] e_dpop; logic e_full, e_rxe;
    logic [15:0] e_rxd; logic [7:0] e_drop; logic e_err;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic wr, logic [15:0] wd, logic pp, logic ps,
                              logic [15:0] pd, logic rd, logic e_pndng, logic [15:0] e_dpop,
                              logic e_full, logic e_rxe, logic [15:0] e_rxd,
                              logic [7:0] e_drop, logic e_err);
    vec_t v;
    v.rst = rst; v.wr = wr; v.wd = wd; v.pp = pp; v.ps = ps; v.pd = pd; v.rd = rd;
    v.e_pndng = e_pndng; v.e_dpop = e_dpop; v.e_full = e_full; v.e_rxe = e_rxe;
    v.e_rxd = e_rxd; v.e_drop = e_drop; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample #1 after the rising edge.
  task automatic cyc(input logic rst, input logic wr, input logic [15:0] wd, input logic pp,
                     input logic ps, input logic [15:0] pd, input logic rd);
    reset = rst; tx_wr = wr; tx_data = wd; pop = pp; push = ps; D_push = pd; rx_rd = rd;
    @(posedge clk);
    #1;
    reset = 1'b0; tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tx_wr = 0; tx_data = 0; pop = 0; push = 0; D_push = 0; rx_rd = 0;
    //              rst wr wd       pp ps pd       rd pndng dpop     full rxe rxd      drop err
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0312, 0, 0, 16'h0000, 0, 1, 16'h0312, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 16'h0999, 1, 1, 16'h0211, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0311, 0, 0, 16'h0000, 0, 1, 16'h0311, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0422, 0, 0, 16'h0000, 0, 1, 16'h0311, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 16'h8F33, 0, 0, 16'h0000, 0, 1, 16'h0311, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0422, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h8F33, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h02AA, 0, 0, 16'h0000, 0, 0, 16'h02AA, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h05BB, 0, 0, 16'h0000, 0, 0, 16'h02AA, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h8FCC, 0, 0, 16'h0000, 0, 0, 16'h02AA, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 1, 16'h00DD, 0, 0, 16'h0000, 0, 0, 16'h02AA, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h8FCC, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0155, 0, 1, 16'h0266, 0, 1, 16'h0155, 0, 0, 16'h0266, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0177, 1, 1, 16'h8F88, 1, 1, 16'h0177, 0, 0, 16'h8F88, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 16'h0444, 1, 0, 16'h0000, 0, 1, 16'h0444, 0, 1, 16'h0000, 0, 1));
    vecs.push_back(mk(1, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h0000, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].wr, vecs[i].wd, vecs[i].pp, vecs[i].ps, vecs[i].pd, vecs[i].rd);
      check($sformatf("row%0d pndng", i),    pndng,    vecs[i].e_pndng);
      check($sformatf("row%0d D_pop", i),    D_pop,    vecs[i].e_dpop);
      check($sformatf("row%0d tx_full", i),  tx_full,  vecs[i].e_full);
      check($sformatf("row%0d rx_empty", i), rx_empty, vecs[i].e_rxe);
      check($sformatf("row%0d rx_data", i),  rx_data,  vecs[i].e_rxd);
      check($sformatf("row%0d drop_cnt", i), drop_cnt, vecs[i].e_drop);
      check($sformatf("row%0d err", i),      err,      vecs[i].e_err);
    end

    // TX fill to full, simultaneous write+pop while full, then an illegal 9th write.
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 16'h0100 + 16'(i), 0, 0, 16'h0, 0);
      exp_q.push_back(16'h0100 + 16'(i));
      check($sformatf("fill%0d tx_full", i), tx_full, (i == 7));
    end
    cyc(0, 1, 16'h0AAA, 1, 0, 16'h0, 0);
    void'(exp_q.pop_front());
    exp_q.push_back(16'h0AAA);
    check("wrpop_full tx_full", tx_full, 1'b1);
    check("wrpop_full err", err, 1'b0);
    check("wrpop_full D_pop", D_pop, 16'h0101);
    cyc(0, 1, 16'h0BBB, 0, 0, 16'h0, 0);
    check("overwrite err", err, 1'b1);
    check("overwrite tx_full", tx_full, 1'b1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d D_pop", i), D_pop, exp_q.pop_front());
      cyc(0, 0, 16'h0, 1, 0, 16'h0, 0);
    end
    check("drained pndng", pndng, 1'b0);
    check("drained tx_full", tx_full, 1'b0);
    cyc(1, 0, 16'h0, 0, 0, 16'h0, 0);

    // RX overflow: 10 accepted pushes into 8 slots, then push+read while full.
    for (int i = 0; i < 10; i++) begin
      cyc(0, 0, 16'h0, 0, 1, 16'h0200 + 16'(i), 0);
      if (i < 8) exp_q.push_back(16'h0200 + 16'(i));
    end
    check("ovf drop_cnt", drop_cnt, 8'd2);
    check("ovf rx_data", rx_data, 16'h0200);
    cyc(0, 0, 16'h0, 0, 1, 16'h0599, 0);
    check("ovf nomatch drop_cnt", drop_cnt, 8'd2);
    cyc(0, 0, 16'h0, 0, 1, 16'h02EE, 1);
    void'(exp_q.pop_front());
    exp_q.push_back(16'h02EE);
    check("push_rd_full drop_cnt", drop_cnt, 8'd2);
    check("push_rd_full rx_data", rx_data, 16'h0201);
    for (int i = 0; i < 300; i++) cyc(0, 0, 16'h0, 0, 1, 16'h8F00, 0);
    check("sat drop_cnt", drop_cnt, 8'd255);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rxdrain%0d rx_data", i), rx_data, exp_q.pop_front());
      cyc(0, 0, 16'h0, 0, 0, 16'h0, 1);
    end
    check("rxdrain rx_empty", rx_empty, 1'b1);
    check("rxdrain err", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
